// File: rtl/shift64_sequencer.sv
// Multi-cycle 64-bit shift/rotate engine with request and response valid/ready handshakes.
// Define SHIFT64_MULTISTEP_EN to advance four steps per cycle while at least four remain.
module shift64_sequencer #(
  parameter int W  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [W-1:0]  req_data,
  input  logic [AW-1:0] req_amt,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          busy
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_acc;
  logic [AW-1:0] r_cnt;
  logic [1:0]    r_op;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_busy;

  logic [W-1:0]  w_step1;
  logic [W-1:0]  w_next_acc;
  logic [AW-1:0] w_next_cnt;
  logic          w_last;

  function automatic logic [W-1:0] f_step(
    input logic [W-1:0] a,
    input logic [1:0]   op
  );
    logic [W-1:0] r;
    case (op)
      OP_SLL:  r = {a[W-2:0], 1'b0};
      OP_SRL:  r = {1'b0, a[W-1:1]};
      OP_SRA:  r = {a[W-1], a[W-1:1]};
      default: r = {a[0], a[W-1:1]};
    endcase
    return r;
  endfunction

  assign w_step1 = f_step(r_acc, r_op);

`ifdef SHIFT64_MULTISTEP_EN
  logic [W-1:0] w_step4;
  logic         w_big;

  assign w_step4    = f_step(f_step(f_step(w_step1, r_op), r_op), r_op);
  assign w_big      = (r_cnt >= AW'(4));
  assign w_next_acc = w_big ? w_step4 : w_step1;
  assign w_next_cnt = r_cnt - (w_big ? AW'(4) : AW'(1));
`else
  assign w_next_acc = w_step1;
  assign w_next_cnt = r_cnt - AW'(1);
`endif

  assign w_last = (w_next_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_op        <= 2'b00;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          if (req_valid && r_req_ready) begin
            r_acc       <= req_data;
            r_cnt       <= req_amt;
            r_op        <= req_op;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (req_amt == '0) begin
              r_state     <= DONE;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_acc <= w_next_acc;
          r_cnt <= w_next_cnt;
          if (w_last) begin
            r_state     <= DONE;
            r_rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          // acc is frozen here, so rsp_data stays stable under backpressure
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_req_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_acc;
  assign busy      = r_busy;

endmodule

// File: tb/tb_shift64_sequencer.sv
// Directed bench for shift64_sequencer: vector table plus backpressure and reset corners.
// Expected latencies follow SHIFT64_MULTISTEP_EN when defined.
module tb_shift64_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_data;
  logic [5:0]  req_amt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift64_sequencer #(.W(64), .AW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] data;
    logic [5:0]  amt;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic int exp_lat(input int amt);
`ifdef SHIFT64_MULTISTEP_EN
    return amt / 4 + amt % 4 + 1;
`else
    return amt + 1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; returns at accept edge +1.
  task automatic do_req(input logic [1:0] op, input logic [63:0] d,
                        input logic [5:0] amt);
    int k = 0;
    while (req_ready !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: got req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_amt   = amt;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int k = 0;
    while (rsp_valid !== 1'b1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got rsp_valid=%b expected 1", rsp_valid);
    end
    lat = k + 1;
  endtask

  task automatic take_rsp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  int lat;
  int seen;

  initial begin
    vecs[0]  = '{2'b00, 64'h0000_0000_0000_0001, 6'd63, 64'h8000_0000_0000_0000};
    vecs[1]  = '{2'b10, 64'h8000_0000_0000_0000, 6'd4,  64'hF800_0000_0000_0000};
    vecs[2]  = '{2'b01, 64'h8000_0000_0000_0000, 6'd4,  64'h0800_0000_0000_0000};
    vecs[3]  = '{2'b11, 64'h0000_0000_0000_0003, 6'd1,  64'h8000_0000_0000_0001};
    vecs[4]  = '{2'b00, 64'h1234_5678_9ABC_DEF0, 6'd0,  64'h1234_5678_9ABC_DEF0};
    vecs[5]  = '{2'b11, 64'h1234_5678_9ABC_DEF0, 6'd4,  64'h0123_4567_89AB_CDEF};
    vecs[6]  = '{2'b10, 64'h7000_0000_0000_0000, 6'd5,  64'h0380_0000_0000_0000};
    vecs[7]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h0000_0000_0000_0001};
    vecs[8]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9]  = '{2'b11, 64'h0000_0000_0000_0001, 6'd63, 64'h0000_0000_0000_0002};
    vecs[10] = '{2'b00, 64'h0000_0000_0000_00FF, 6'd8,  64'h0000_0000_0000_FF00};
    vecs[11] = '{2'b00, 64'h0000_0000_0000_00F0, 6'd6,  64'h0000_0000_0000_3C00};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = '0;
    req_amt   = '0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_rsp_data",  rsp_data,           64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].op, vecs[i].data, vecs[i].amt);
      wait_rsp(lat);
      chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp);
      chk($sformatf("vec%0d_lat", i), 64'(lat),
          64'(exp_lat(int'(vecs[i].amt))));
      take_rsp();
    end

    // Backpressure: response held, next request pending but blocked
    do_req(2'b00, 64'h5, 6'd3);
    wait_rsp(lat);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = 64'hF0;
    req_amt   = 6'd4;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_data",  rsp_data,           64'h28);
      chk("bp_ready", {63'd0, req_ready}, 64'd0);
    end
    take_rsp();
    chk("bp_ready_after", {63'd0, req_ready}, 64'd1);
    chk("bp_valid_after", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_accept_busy", {63'd0, busy}, 64'd1);
    wait_rsp(lat);
    chk("bp_next_data", rsp_data, 64'h0F);
    chk("bp_next_lat", 64'(lat), 64'(exp_lat(4)));
    take_rsp();

    // Reset in the middle of a long shift
    do_req(2'b01, 64'hFFFF_0000_0000_0000, 6'd40);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy",  {63'd0, busy},      64'd0);
    chk("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
    rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    rsp_ready = 1'b0;
    chk("mid_rst_no_rsp", 64'(seen), 64'd0);
    chk("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    do_req(2'b01, 64'hFFFF_0000_0000_0000, 6'd40);
    wait_rsp(lat);
    chk("after_rst_data", rsp_data, 64'h0000_0000_00FF_FF00);
    chk("after_rst_lat", 64'(lat), 64'(exp_lat(40)));
    take_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
